uart_rx_framer: RTL and testbench

Packet framer and sequencer placed directly after the UART byte receiver. It consumes the receiver's one-cycle byte strobes, hunts for a sync byte, and parses a command/length/payload/checksum frame into an internal payload buffer. It then hands the completed packet to the command logic through a valid/ready handshake. Inter-byte timeouts, oversize lengths and checksum failures abort the frame, report an error, and return the block to hunting.

---
 rtl/uart_rx_framer.sv | 138 +++++++++++++
 tb/tb_uart_rx_framer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: sync-hunting CMD/LEN/payload/checksum framer with valid/ready hand-off; define UART_RX_FRAMER_STATS_EN for good/error counters
module uart_rx_framer #(
    parameter int MAX_PAYLOAD = 16,
    parameter int TIMEOUT_CLKS = 2170,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    localparam int AW = $clog2(MAX_PAYLOAD),
    localparam int LW = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic          i_Clock,
    input  logic          i_Rst,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte,
    output logic          o_Pkt_Valid,
    input  logic          i_Pkt_Ready,
    output logic [7:0]    o_Pkt_Cmd,
    output logic [LW-1:0] o_Pkt_Len,
    input  logic [AW-1:0] i_Rd_Addr,
    output logic [7:0]    o_Rd_Data,
    output logic          o_Err_Checksum,
    output logic          o_Err_Length,
    output logic          o_Err_Timeout,
    output logic          o_Drop,
    output logic          o_Busy,
    output logic [15:0]   o_Good_Count,
    output logic [15:0]   o_Err_Count
);
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHK, HOLD} state_t;
    state_t state, state_n;
    logic [7:0] sum, sum_n, sum_add, cmd_n;
    logic [LW-1:0] len_n, idx, idx_n, idx_inc;
    logic [CW-1:0] tcnt, tcnt_n;
    logic in_frame, tmo, wr_en, err_cs_n, err_len_n, err_to_n, drop_n;
    logic [7:0] mem [MAX_PAYLOAD];
    always_comb begin
        in_frame = state inside {CMD, LEN, PAYLOAD, CHK};
        tmo = in_frame && !i_RX_DV && tcnt == CW'(TIMEOUT_CLKS - 1);
        sum_add = sum + i_RX_Byte;
        idx_inc = idx + 1'b1;
        tcnt_n = (in_frame && !i_RX_DV) ? tcnt + 1'b1 : '0;
        state_n = state;
        sum_n = sum;
        cmd_n = o_Pkt_Cmd;
        len_n = o_Pkt_Len;
        idx_n = idx;
        wr_en = 1'b0;
        err_cs_n = 1'b0;
        err_len_n = 1'b0;
        err_to_n = 1'b0;
        drop_n = 1'b0;
        if (tmo) begin
            state_n = HUNT;
            err_to_n = 1'b1;
        end else if (i_RX_DV) begin
            case (state)
                HUNT: begin
                    state_n = i_RX_Byte == SYNC_BYTE ? CMD : HUNT;
                    sum_n = '0;
                end
                CMD: begin
                    cmd_n = i_RX_Byte;
                    sum_n = sum_add;
                    state_n = LEN;
                end
                LEN: begin
                    sum_n = sum_add;
                    err_len_n = i_RX_Byte > 8'(MAX_PAYLOAD);
                    len_n = err_len_n ? o_Pkt_Len : LW'(i_RX_Byte);
                    idx_n = '0;
                    state_n = err_len_n ? HUNT : (i_RX_Byte == 8'd0 ? CHK : PAYLOAD);
                end
                PAYLOAD: begin
                    wr_en = 1'b1;
                    sum_n = sum_add;
                    idx_n = idx_inc;
                    state_n = idx_inc == o_Pkt_Len ? CHK : PAYLOAD;
                end
                CHK: begin
                    err_cs_n = sum_add != 8'd0;
                    state_n = err_cs_n ? HUNT : HOLD;
                end
                default: drop_n = 1'b1;
            endcase
        end
        // acceptance overrides any byte seen in HOLD; that byte is still reported as dropped
        if (state == HOLD && i_Pkt_Ready) state_n = HUNT;
    end
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state <= HUNT;
            sum <= '0;
            idx <= '0;
            tcnt <= '0;
            o_Pkt_Cmd <= '0;
            o_Pkt_Len <= '0;
            o_Pkt_Valid <= 1'b0;
            o_Busy <= 1'b0;
            o_Err_Checksum <= 1'b0;
            o_Err_Length <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Drop <= 1'b0;
        end else begin
            state <= state_n;
            sum <= sum_n;
            idx <= idx_n;
            tcnt <= tcnt_n;
            o_Pkt_Cmd <= cmd_n;
            o_Pkt_Len <= len_n;
            o_Pkt_Valid <= state_n == HOLD;
            o_Busy <= state_n != HUNT;
            o_Err_Checksum <= err_cs_n;
            o_Err_Length <= err_len_n;
            o_Err_Timeout <= err_to_n;
            o_Drop <= drop_n;
        end
    end
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem[idx[AW-1:0]] <= i_RX_Byte;
    end
    always_ff @(posedge i_Clock) begin
        if (i_Rst) o_Rd_Data <= '0;
        else o_Rd_Data <= mem[i_Rd_Addr];
    end
`ifdef UART_RX_FRAMER_STATS_EN
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            o_Good_Count <= '0;
            o_Err_Count <= '0;
        end else begin
            if (state_n == HOLD && state != HOLD && o_Good_Count != 16'hFFFF) o_Good_Count <= o_Good_Count + 16'd1;
            if ((err_cs_n || err_len_n || err_to_n) && o_Err_Count != 16'hFFFF) o_Err_Count <= o_Err_Count + 16'd1;
        end
    end
`else
    assign o_Good_Count = '0;
    assign o_Err_Count = '0;
`endif
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed test-plan cases plus randomized frames against a frame-level reference model
module tb_uart_rx_framer;
    localparam int MAXP = 16;
    localparam int TMO = 2170;
    localparam int AW = $clog2(MAXP);
    localparam int LW = $clog2(MAXP + 1);
`ifdef UART_RX_FRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_dv = 1'b0;
    logic [7:0] rx_byte = '0;
    logic ready = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic pkt_valid, err_cs, err_len, err_to, drop, busy;
    logic [7:0] pkt_cmd, rd_data;
    logic [LW-1:0] pkt_len;
    logic [15:0] good_count, err_count;
    always #5 clk = ~clk;
    uart_rx_framer #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
        .i_Clock(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .o_Pkt_Valid(pkt_valid), .i_Pkt_Ready(ready), .o_Pkt_Cmd(pkt_cmd), .o_Pkt_Len(pkt_len),
        .i_Rd_Addr(rd_addr), .o_Rd_Data(rd_data), .o_Err_Checksum(err_cs), .o_Err_Length(err_len),
        .o_Err_Timeout(err_to), .o_Drop(drop), .o_Busy(busy),
        .o_Good_Count(good_count), .o_Err_Count(err_count)
    );
    int errors = 0, checks = 0;
    int exp_good = 0, exp_err = 0;
    int n_valid = 0, n_vcyc = 0, n_cs = 0, n_len = 0, n_to = 0, n_drop = 0;
    int s_v, s_vc, s_cs, s_len, s_to, s_dr;
    logic pv = 1'b0;
    logic [7:0] cap_cmd = '0;
    logic [LW-1:0] cap_len = '0;
    always @(negedge clk) begin
        pv <= pkt_valid;
        if (pkt_valid && !pv) begin
            n_valid <= n_valid + 1;
            cap_cmd <= pkt_cmd;
            cap_len <= pkt_len;
        end
        if (pkt_valid) n_vcyc <= n_vcyc + 1;
        if (err_cs) n_cs <= n_cs + 1;
        if (err_len) n_len <= n_len + 1;
        if (err_to) n_to <= n_to + 1;
        if (drop) n_drop <= n_drop + 1;
    end
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic take_snap();
        s_v = n_valid; s_vc = n_vcyc; s_cs = n_cs; s_len = n_len; s_to = n_to; s_dr = n_drop;
    endtask
    task automatic expect_d(input string tag, input int v, input int cs, input int ln, input int to, input int dr);
        check({tag, "_valid"}, n_valid - s_v, v);
        check({tag, "_errcs"}, n_cs - s_cs, cs);
        check({tag, "_errlen"}, n_len - s_len, ln);
        check({tag, "_errto"}, n_to - s_to, to);
        check({tag, "_drop"}, n_drop - s_dr, dr);
    endtask
    task automatic send(input logic [7:0] b, input int idle);
        repeat (idle) @(negedge clk);
        @(negedge clk);
        rx_dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask
    task automatic send_q(input logic [7:0] q[$], input int n);
        for (int i = 0; i < n; i++) send(q[i], $urandom_range(0, 2));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        rx_dv = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_good = 0;
        exp_err = 0;
    endtask
    task automatic read_chk(input string tag, input int a, input logic [7:0] e);
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        check(tag, rd_data, e);
    endtask
    task automatic accept(input bit with_dv, input logic [7:0] b);
        @(negedge clk);
        ready = 1'b1;
        if (with_dv) begin
            rx_dv = 1'b1;
            rx_byte = b;
        end
        @(negedge clk);
        ready = 1'b0;
        rx_dv = 1'b0;
        check("valid_after_accept", pkt_valid, 0);
        check("busy_after_accept", busy, 0);
    endtask
    function automatic logic [7:0] noise();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hA5);
        return b;
    endfunction
    task automatic rand_frame();
        int kind, s, nd, acc, nsend;
        logic [7:0] cmd, len, chk;
        logic [7:0] pay[$];
        logic [7:0] q[$];
        bit good;
        kind = $urandom_range(0, 9);
        repeat ($urandom_range(0, 3)) send(noise(), $urandom_range(0, 2));
        take_snap();
        cmd = 8'($urandom);
        len = (kind == 7 || kind == 8) ? 8'($urandom_range(MAXP + 1, 255)) : 8'($urandom_range(0, MAXP));
        pay.delete();
        s = cmd + len;
        for (int i = 0; i < len && i < MAXP; i++) begin
            pay.push_back(8'($urandom));
            s += pay[i];
        end
        chk = 8'(256 - s % 256);
        if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
        q = {8'hA5, cmd, len};
        foreach (pay[i]) q.push_back(pay[i]);
        q.push_back(chk);
        if (kind == 7 || kind == 8) begin
            send_q(q, 3);
            send(noise(), $urandom_range(0, 2));
            @(negedge clk);
            expect_d("rnd_oversize", 0, 0, 1, 0, 0);
            check("rnd_oversize_busy", busy, 0);
            exp_err++;
        end else if (kind == 9) begin
            nsend = 1 + $urandom_range(0, 2 + int'(len));
            send_q(q, nsend);
            repeat (TMO + 2) @(negedge clk);
            expect_d("rnd_timeout", 0, 0, 0, 1, 0);
            check("rnd_timeout_busy", busy, 0);
            exp_err++;
        end else begin
            good = ((s + chk) % 256) == 0;
            send_q(q, q.size());
            @(negedge clk);
            if (good) begin
                check("rnd_hold_valid", pkt_valid, 1);
                check("rnd_cmd", cap_cmd, cmd);
                check("rnd_len", cap_len, len);
                nd = $urandom_range(0, 2);
                repeat (nd) send($urandom_range(0, 1) ? 8'hA5 : 8'($urandom), $urandom_range(0, 2));
                check("rnd_cmd_stable", pkt_cmd, cmd);
                check("rnd_len_stable", pkt_len, len);
                foreach (pay[i]) read_chk("rnd_payload", i, pay[i]);
                acc = $urandom_range(0, 1);
                accept(acc[0], 8'hA5);
                @(negedge clk);
                expect_d("rnd_good", 1, 0, 0, 0, nd + acc);
                exp_good++;
            end else begin
                expect_d("rnd_badchk", 0, 1, 0, 0, 0);
                check("rnd_badchk_busy", busy, 0);
                exp_err++;
            end
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
    initial begin
        do_reset();
        check("rst_valid", pkt_valid, 0);
        check("rst_cmd", pkt_cmd, 0);
        check("rst_len", pkt_len, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_errs", {err_cs, err_len, err_to, drop}, 0);
        check("rst_busy", busy, 0);
        check("rst_good_count", good_count, 0);
        check("rst_err_count", err_count, 0);
        ready = 1'b1;
        take_snap();
        send_q({8'hA5, 8'h10, 8'h02, 8'h11}, 4);
        send(8'h22, 0);
        send(8'hBB, 0);
        check("good_valid_rise", pkt_valid, 1);
        @(negedge clk);
        check("good_valid_fall", pkt_valid, 0);
        check("good_valid_cycles", n_vcyc - s_vc, 1);
        expect_d("good", 1, 0, 0, 0, 0);
        check("good_cmd", cap_cmd, 8'h10);
        check("good_len", cap_len, 2);
        read_chk("good_rd0", 0, 8'h11);
        read_chk("good_rd1", 1, 8'h22);
        take_snap();
        send_q({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h20, 8'h00, 8'hE0}, 7);
        @(negedge clk);
        expect_d("zero_len", 1, 0, 0, 0, 0);
        check("zero_len_cmd", cap_cmd, 8'h20);
        check("zero_len_len", cap_len, 0);
        take_snap();
        send_q({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBC}, 6);
        @(negedge clk);
        expect_d("badchk", 0, 1, 0, 0, 0);
        take_snap();
        send_q({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB}, 6);
        @(negedge clk);
        expect_d("after_badchk", 1, 0, 0, 0, 0);
        take_snap();
        send_q({8'hA5, 8'h10, 8'h11, 8'h00}, 4);
        @(negedge clk);
        expect_d("oversize", 0, 0, 1, 0, 0);
        check("oversize_busy", busy, 0);
        take_snap();
        send(8'hA5, 0);
        send(8'h10, 0);
        repeat (TMO - 1) @(negedge clk);
        check("timeout_early", err_to, 0);
        check("timeout_busy", busy, 1);
        @(negedge clk);
        check("timeout_pulse", err_to, 1);
        @(negedge clk);
        check("timeout_after", err_to, 0);
        check("timeout_idle", busy, 0);
        expect_d("timeout", 0, 0, 0, 1, 0);
        take_snap();
        send(8'hA5, 0);
        send(8'h10, 0);
        send(8'h00, TMO - 2);
        send(8'hF0, 0);
        @(negedge clk);
        expect_d("terminal_byte", 1, 0, 0, 0, 0);
        take_snap();
        send(8'hA5, 0);
        send(8'h10, 0);
        send(8'h00, TMO - 1);
        send(8'hF0, 0);
        @(negedge clk);
        expect_d("late_byte", 0, 0, 0, 1, 0);
        do_reset();
        take_snap();
        send_q({8'hA5, 8'h40, 8'h01, 8'h77, 8'h48}, 5);
        @(negedge clk);
        check("bp_valid", pkt_valid, 1);
        send(8'hA5, 0);
        send(8'h30, 1);
        @(negedge clk);
        expect_d("bp", 1, 0, 0, 0, 2);
        check("bp_cmd", pkt_cmd, 8'h40);
        check("bp_len", pkt_len, 1);
        check("bp_still_valid", pkt_valid, 1);
        read_chk("bp_rd0", 0, 8'h77);
        accept(1'b0, 8'h00);
        check("bp_good_count", good_count, STATS ? 1 : 0);
        check("bp_err_count", err_count, 0);
        send_q({8'hA5, 8'h10, 8'h02, 8'h11}, 4);
        take_snap();
        do_reset();
        @(negedge clk);
        check("midrst_busy", busy, 0);
        expect_d("midrst", 0, 0, 0, 0, 0);
        send_q({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB}, 6);
        @(negedge clk);
        check("midrst_then_good", pkt_valid, 1);
        accept(1'b0, 8'h00);
        exp_good++;
        for (int n = 0; n < 40; n++) rand_frame();
        check("final_good_count", good_count, STATS ? exp_good : 0);
        check("final_err_count", err_count, STATS ? exp_err : 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
